frf_rw_buf: RTL

- Parametrised successor to the single-port floating-point register file in the SPARC core tile.
- Contains its own DEPTH x WIDTH array, split into LANES independently writable lanes.
- Adds a hardware clear sweep after reset and a one-entry write buffer. The buffer lets a read and a write issue in the same cycle without losing the read; buffered data is forwarded to colliding reads.
- Sits between the FFU control/datapath and the FP register storage; read latency is 2 cycles, as in the current FRF.

---
 rtl/frf_pkg.sv | 17 +
 rtl/frf_rw_buf_if.sv | 16 +
 rtl/frf_array.sv | 17 +
 rtl/frf_rw_buf.sv | 73 +++++++
 4 files changed

// File: rtl/frf_pkg.sv
// frf_pkg: shared state type, default geometry and lane-mask helper for the FRF slice
package frf_pkg;
  localparam int FRF_WIDTH = 78;
  localparam int FRF_DEPTH = 128;
  localparam int FRF_LANES = 2;
  localparam int FRF_MAXW = 1024;
  localparam int FRF_MAXL = 16;
  typedef enum logic {CLEAR, RUN} frf_state_e;
  function automatic logic [FRF_MAXW-1:0] lane_expand(input logic [FRF_MAXL-1:0] m, input int lw);
    logic [FRF_MAXW-1:0] ones;
    logic [FRF_MAXW-1:0] r;
    ones = (FRF_MAXW'(1) << lw) - FRF_MAXW'(1);
    r = '0;
    for (int i = 0; i < FRF_MAXL; i++) if (m[i]) r = r | (ones << (i * lw));
    return r;
  endfunction
endpackage

// File: rtl/frf_rw_buf_if.sv
// frf_rw_buf_if: request/response bundle between the FFU and the FP register file
interface frf_rw_buf_if import frf_pkg::*; #(parameter int WIDTH = FRF_WIDTH, LANES = FRF_LANES, AW = $clog2(FRF_DEPTH));
  logic ctl_frf_ren;
  logic [LANES-1:0] ctl_frf_wen;
  logic [AW-1:0] ctl_frf_addr;
  logic [WIDTH-1:0] dp_frf_data;
  logic [WIDTH-1:0] frf_dp_data;
  logic frf_dp_vld;
  logic frf_busy;
  logic frf_stall;
  logic frf_err;
  modport master (output ctl_frf_ren, ctl_frf_wen, ctl_frf_addr, dp_frf_data,
                  input frf_dp_data, frf_dp_vld, frf_busy, frf_stall, frf_err);
  modport slave (input ctl_frf_ren, ctl_frf_wen, ctl_frf_addr, dp_frf_data,
                 output frf_dp_data, frf_dp_vld, frf_busy, frf_stall, frf_err);
endinterface

// File: rtl/frf_array.sv
// frf_array: DEPTH x WIDTH storage, lane-masked write, one synchronous access port
module frf_array #(parameter int WIDTH = 78, DEPTH = 128, LANES = 2, AW = $clog2(DEPTH)) (
  input  logic             rclk,
  input  logic             we,
  input  logic             re,
  input  logic [LANES-1:0] wmask,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  localparam int LW = WIDTH / LANES;
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge rclk) begin
    for (int i = 0; i < LANES; i++) if (we && wmask[i]) mem[addr][i*LW +: LW] <= wdata[i*LW +: LW];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/frf_rw_buf.sv
// frf_rw_buf: FP register file with post-reset clear sweep, one-entry write buffer and read forwarding
module frf_rw_buf import frf_pkg::*; #(
  parameter int WIDTH = FRF_WIDTH,
  parameter int DEPTH = FRF_DEPTH,
  parameter int LANES = FRF_LANES,
  parameter int AW = $clog2(DEPTH)
) (
  input logic rclk,
  input logic rst_n,
  frf_rw_buf_if.slave bus
);
  localparam int LW = WIDTH / LANES;
  frf_state_e state;
  logic [AW-1:0] ptr, buf_addr, arr_addr;
  logic [WIDTH-1:0] buf_data, fwd_data_q, arr_rdata, arr_wdata, fwd_bits, dp_data;
  logic [LANES-1:0] buf_mask, fwd_mask_q, arr_mask;
  logic buf_vld, rd_q, dp_vld, err, run, addr_ok, any_req, ren, wr, drain, arr_we, capture;
  assign run = state == RUN;
  assign addr_ok = int'(bus.ctl_frf_addr) < DEPTH;
  assign any_req = bus.ctl_frf_ren | (|bus.ctl_frf_wen);
  assign ren = run & addr_ok & bus.ctl_frf_ren;
  assign wr = run & addr_ok & (|bus.ctl_frf_wen);
  // the buffer owns the array port whenever no read claims it
  assign drain = run & ~ren & buf_vld;
  assign capture = wr & (ren != buf_vld);
  assign arr_we = ~run | drain | (wr & ~ren);
  assign arr_addr = ~run ? ptr : drain ? buf_addr : bus.ctl_frf_addr;
  assign arr_mask = ~run ? '1 : drain ? buf_mask : bus.ctl_frf_wen;
  assign arr_wdata = ~run ? '0 : drain ? buf_data : bus.dp_frf_data;
  assign fwd_bits = WIDTH'(lane_expand(FRF_MAXL'(fwd_mask_q), LW));
  frf_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES), .AW(AW)) u_array (
    .rclk(rclk), .we(arr_we), .re(ren), .wmask(arr_mask),
    .addr(arr_addr), .wdata(arr_wdata), .rdata(arr_rdata)
  );
  always_ff @(posedge rclk or negedge rst_n)
    if (!rst_n) begin
      state <= CLEAR;
      ptr <= '0;
      buf_vld <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      buf_mask <= '0;
      rd_q <= 1'b0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
      dp_data <= '0;
      dp_vld <= 1'b0;
      err <= 1'b0;
    end else begin
      if (!run) begin
        ptr <= ptr + AW'(1);
        if (ptr == AW'(DEPTH - 1)) state <= RUN;
      end
      if (capture) begin
        buf_vld <= 1'b1;
        buf_addr <= bus.ctl_frf_addr;
        buf_data <= bus.dp_frf_data;
        buf_mask <= bus.ctl_frf_wen;
      end else if (drain && !wr) buf_vld <= 1'b0;
      if (run && ((ren && wr && buf_vld) || (!addr_ok && any_req))) err <= 1'b1;
      // a write captured this cycle is deliberately not visible to the same-cycle read
      rd_q <= ren;
      fwd_mask_q <= (ren && buf_vld && buf_addr == bus.ctl_frf_addr) ? buf_mask : '0;
      fwd_data_q <= buf_data;
      dp_vld <= rd_q;
      if (rd_q) dp_data <= (arr_rdata & ~fwd_bits) | (fwd_data_q & fwd_bits);
    end
  assign bus.frf_dp_data = dp_data;
  assign bus.frf_dp_vld = dp_vld;
  assign bus.frf_busy = ~run;
  assign bus.frf_stall = buf_vld;
  assign bus.frf_err = err;
endmodule
